// File: rtl/keypad_ssd_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_ssd_scanner_if
// Bundles the key-entry inputs and display/status outputs of keypad_ssd_scanner.
//   master : upstream key source / display consumer (drives key_valid, key_code,
//            clear; observes seg, digit_sel, digits, digit_valid, entry_count)
//   slave  : the scanner itself
// Signals:
//   key_valid   1-cycle pulse per accepted key press
//   key_code    4-bit hex code, sampled with key_valid
//   clear       1-cycle pulse erasing all entries
//   seg         active-high segments {a,b,c,d,e,f,g}
//   digit_sel   index of the slot currently shown on seg
//   digits      flat digit registers, slot k at [4k+3:4k]
//   digit_valid per-slot "entered since clear" mask
//   entry_count keys accepted since clear/reset, saturating at 255
// -----------------------------------------------------------------------------
interface keypad_ssd_scanner_if #(
   parameter int NUM_DIGITS = 2
);
   localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                    key_valid;
   logic [3:0]              key_code;
   logic                    clear;
   logic [6:0]              seg;
   logic [SEL_W-1:0]        digit_sel;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic [7:0]              entry_count;

   modport master (
      output key_valid, key_code, clear,
      input  seg, digit_sel, digits, digit_valid, entry_count
   );

   modport slave (
      input  key_valid, key_code, clear,
      output seg, digit_sel, digits, digit_valid, entry_count
   );
endinterface

// File: rtl/keypad_ssd_scanner.sv
// -----------------------------------------------------------------------------
// keypad_ssd_scanner
// Captures accepted key codes into NUM_DIGITS digit slots and time-multiplexes
// them onto one shared 7-segment bus with a registered digit select.
// Parameters:
//   clk_freq, refresh_hz : digit-advance period DIV = clk_freq/refresh_hz (>= 2)
//   NUM_DIGITS           : number of slots, 1..8
//   ENTRY_MODE           : 0 = round-robin overwrite, 1 = shift-left entry
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  keypad_ssd_scanner_if.slave (key inputs, segment/status outputs)
// -----------------------------------------------------------------------------
module keypad_ssd_scanner #(
   parameter int clk_freq   = 125_000_000,
   parameter int refresh_hz = 1000,
   parameter int NUM_DIGITS = 2,
   parameter int ENTRY_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   keypad_ssd_scanner_if.slave  bus
);
   localparam int DIV   = clk_freq / refresh_hz;
   localparam int CNT_W = $clog2(DIV);
   localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW    = 4 * NUM_DIGITS;

   logic [DW-1:0]         digits_q,  digits_d;
   logic [NUM_DIGITS-1:0] valid_q,   valid_d;
   logic [7:0]            count_q,   count_d;
   logic [SEL_W-1:0]      wr_ptr_q,  wr_ptr_d;
   logic [SEL_W-1:0]      scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0]      refresh_q, refresh_d;
   logic [6:0]            seg_q,     seg_d;
   logic [SEL_W-1:0]      sel_q,     sel_d;

   // Hex font, segments {a,b,c,d,e,f,g}, active high.
   function automatic logic [6:0] hex_font(input logic [3:0] v);
      case (v)
         4'h0: hex_font = 7'b1111110;
         4'h1: hex_font = 7'b0110000;
         4'h2: hex_font = 7'b1101101;
         4'h3: hex_font = 7'b1111001;
         4'h4: hex_font = 7'b0110011;
         4'h5: hex_font = 7'b1011011;
         4'h6: hex_font = 7'b1011111;
         4'h7: hex_font = 7'b1110000;
         4'h8: hex_font = 7'b1111111;
         4'h9: hex_font = 7'b1111011;
         4'hA: hex_font = 7'b1110111;
         4'hB: hex_font = 7'b0011111;
         4'hC: hex_font = 7'b1001110;
         4'hD: hex_font = 7'b0111101;
         4'hE: hex_font = 7'b1001111;
         4'hF: hex_font = 7'b1000111;
      endcase
   endfunction

   // Entry path: clear beats a simultaneous key.
   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch can leave one
      // unassigned and the block stays purely combinational (no latches).
      digits_d = digits_q;
      valid_d  = valid_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;

      if (bus.clear) begin
         digits_d = '0;
         valid_d  = '0;
         count_d  = '0;
         wr_ptr_d = '0;
      end else if (bus.key_valid) begin
         if (ENTRY_MODE == 0) begin
            digits_d[4*int'(wr_ptr_q) +: 4] = bus.key_code;
            valid_d[wr_ptr_q]               = 1'b1;
            wr_ptr_d = (wr_ptr_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : wr_ptr_q + 1'b1;
         end else begin
            // Shift-left: slot k moves to k+1, the top slot falls off.
            for (int k = NUM_DIGITS - 1; k > 0; k--) begin
               digits_d[4*k +: 4] = digits_q[4*(k-1) +: 4];
               valid_d[k]         = valid_q[k-1];
            end
            digits_d[3:0] = bus.key_code;
            valid_d[0]    = 1'b1;
         end
         if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
   end

   // Scan path: slot index advances once per DIV cycles; the output register
   // samples slot and select together so seg always matches digit_sel.
   always_comb begin
      refresh_d  = refresh_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (refresh_q == CNT_W'(DIV - 1)) begin
         refresh_d  = '0;
         scan_idx_d = (scan_idx_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end
      sel_d = scan_idx_q;
      seg_d = valid_q[scan_idx_q] ? hex_font(digits_q[4*int'(scan_idx_q) +: 4]) : 7'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the digit slots are ordinary flops rather than a RAM, so they
         // take a reset value like everything else.
         digits_q   <= '0;
         valid_q    <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         scan_idx_q <= '0;
         refresh_q  <= '0;
         seg_q      <= '0;
         sel_q      <= '0;
      end else begin
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         scan_idx_q <= scan_idx_d;
         refresh_q  <= refresh_d;
         seg_q      <= seg_d;
         sel_q      <= sel_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.digit_sel   = sel_q;
   assign bus.digits      = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.entry_count = count_q;

endmodule

// File: tb/tb_keypad_ssd_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_ssd_scanner
// Drives one scanner per entry mode (DIV = 8, four digits) with identical key
// traffic. A behavioural model tracks the entered digits as integer lists and
// derives the scan position from elapsed cycles; a negedge process compares
// both DUTs against it every cycle. Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_keypad_ssd_scanner;
   localparam int N   = 4;
   localparam int DIV = 8;

   localparam logic [6:0] FONT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_ssd_scanner_if #(.NUM_DIGITS(N)) bus0 ();
   keypad_ssd_scanner_if #(.NUM_DIGITS(N)) bus1 ();

   keypad_ssd_scanner #(.clk_freq(8), .refresh_hz(1), .NUM_DIGITS(N), .ENTRY_MODE(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   keypad_ssd_scanner #(.clk_freq(8), .refresh_hz(1), .NUM_DIGITS(N), .ENTRY_MODE(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_dig  [2][N];
   bit         m_val  [2][N];
   int         m_cnt  [2];
   int         m_keys [2];     // keys since clear/reset, unsaturated
   longint     t_cyc;          // clock edges since reset
   int         e_sel  [2];
   logic [6:0] e_seg  [2];
   bit         ready = 1'b0;

   task automatic model_entry(input int m, input bit kv, input int kc, input bit clr);
      if (clr) begin
         for (int k = 0; k < N; k++) begin m_dig[m][k] = 0; m_val[m][k] = 0; end
         m_cnt[m]  = 0;
         m_keys[m] = 0;
      end else if (kv) begin
         if (m == 0) begin
            m_dig[m][m_keys[m] % N] = kc;
            m_val[m][m_keys[m] % N] = 1;
         end else begin
            for (int k = N - 1; k > 0; k--) begin
               m_dig[m][k] = m_dig[m][k-1];
               m_val[m][k] = m_val[m][k-1];
            end
            m_dig[m][0] = kc;
            m_val[m][0] = 1;
         end
         m_keys[m]++;
         m_cnt[m] = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            model_entry(m, 1'b0, 0, 1'b1);
            e_sel[m] = 0;
            e_seg[m] = 7'b0;
         end
         t_cyc = 0;
         ready = 1'b1;
      end else begin
         for (int m = 0; m < 2; m++) begin
            int cur;
            cur      = int'((t_cyc / DIV) % N);
            e_sel[m] = cur;
            e_seg[m] = m_val[m][cur] ? FONT[m_dig[m][cur]] : 7'b0;
         end
         model_entry(0, bus0.key_valid, int'(bus0.key_code), bus0.clear);
         model_entry(1, bus1.key_valid, int'(bus1.key_code), bus1.clear);
         t_cyc++;
      end
   end

   task automatic compare(input int m, input logic [6:0] seg, input logic [1:0] sel,
                          input logic [15:0] digs, input logic [3:0] val, input logic [7:0] cnt);
      logic [15:0] ed;
      logic [3:0]  ev;
      for (int k = 0; k < N; k++) begin
         ed[4*k +: 4] = m_dig[m][k][3:0];
         ev[k]        = m_val[m][k];
      end
      check($sformatf("m%0d seg", m), 64'(seg), 64'(e_seg[m]));
      check($sformatf("m%0d digit_sel", m), 64'(sel), 64'(e_sel[m]));
      check($sformatf("m%0d digits", m), 64'(digs), 64'(ed));
      check($sformatf("m%0d digit_valid", m), 64'(val), 64'(ev));
      check($sformatf("m%0d entry_count", m), 64'(cnt), 64'(m_cnt[m]));
   endtask

   always @(negedge clk) begin
      if (ready) begin
         compare(0, bus0.seg, bus0.digit_sel, bus0.digits, bus0.digit_valid, bus0.entry_count);
         compare(1, bus1.seg, bus1.digit_sel, bus1.digits, bus1.digit_valid, bus1.entry_count);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit kv, input logic [3:0] kc, input bit clr);
      bus0.key_valid = kv; bus0.key_code = kc; bus0.clear = clr;
      bus1.key_valid = kv; bus1.key_code = kc; bus1.clear = clr;
      @(negedge clk);
      bus0.key_valid = 1'b0; bus0.clear = 1'b0;
      bus1.key_valid = 1'b0; bus1.clear = 1'b0;
   endtask

   task automatic wait_sel(input int want, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 5 * DIV && !found; i++) begin
         if (int'(bus0.digit_sel) == want) found = 1'b1;
         else @(negedge clk);
      end
      check({name, " wait digit_sel"}, 64'(found), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   localparam int STEP_K [5] = '{8, 9, 17, 25, 33};
   localparam int STEP_E [5] = '{0, 1, 2, 3, 0};

   initial begin
      bus0.key_valid = 1'b0; bus0.key_code = 4'h0; bus0.clear = 1'b0;
      bus1.key_valid = 1'b0; bus1.key_code = 4'h0; bus1.clear = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1. reset state and blank scan 0,1,2,3,0 every DIV cycles
      check("rst seg", 64'(bus0.seg), 64'd0);
      check("rst digit_sel", 64'(bus0.digit_sel), 64'd0);
      check("rst digits", 64'(bus0.digits), 64'd0);
      check("rst digit_valid", 64'(bus0.digit_valid), 64'd0);
      check("rst entry_count", 64'(bus0.entry_count), 64'd0);
      begin
         int j = 0;
         for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (j < 5 && k == STEP_K[j]) begin
               check($sformatf("scan step %0d", k), 64'(bus0.digit_sel), 64'(STEP_E[j]));
               check($sformatf("scan blank %0d", k), 64'(bus0.seg), 64'd0);
               j++;
            end
         end
      end

      // 3. shift-left entry: keys A,2
      drive(1'b1, 4'hA, 1'b0);
      drive(1'b1, 4'h2, 1'b0);
      check("m1 slot0", 64'(bus1.digits[3:0]), 64'h2);
      check("m1 slot1", 64'(bus1.digits[7:4]), 64'hA);
      check("m1 valid", 64'(bus1.digit_valid), 64'b0011);
      wait_sel(1, "m1 sel1");
      check("m1 seg sel1", 64'(bus1.seg), 64'b1110111);
      wait_sel(2, "m1 sel2");
      check("m1 seg sel2", 64'(bus1.seg), 64'b0000000);

      // 2. round-robin entry: keys 1..5 after a clear
      drive(1'b0, 4'h0, 1'b1);
      for (int k = 1; k <= 5; k++) drive(1'b1, 4'(k), 1'b0);
      check("m0 digits", 64'(bus0.digits), 64'h4325);
      check("m0 valid", 64'(bus0.digit_valid), 64'b1111);
      check("m0 count", 64'(bus0.entry_count), 64'd5);
      check("m1 digits", 64'(bus1.digits), 64'h2345);
      wait_sel(0, "m0 sel0");
      check("m0 seg sel0", 64'(bus0.seg), 64'b1011011);

      // 4. clear beats a simultaneous key
      drive(1'b0, 4'h0, 1'b1);
      drive(1'b1, 4'h1, 1'b0);
      drive(1'b1, 4'h2, 1'b0);
      drive(1'b1, 4'h3, 1'b0);
      drive(1'b1, 4'h8, 1'b1);
      check("clr m0 digits", 64'(bus0.digits), 64'd0);
      check("clr m0 valid", 64'(bus0.digit_valid), 64'd0);
      check("clr m0 count", 64'(bus0.entry_count), 64'd0);
      check("clr m1 digits", 64'(bus1.digits), 64'd0);
      check("clr m1 valid", 64'(bus1.digit_valid), 64'd0);

      // 5. saturation: key_valid held for 300 cycles
      bus0.key_valid = 1'b1; bus0.key_code = 4'h7;
      bus1.key_valid = 1'b1; bus1.key_code = 4'h7;
      repeat (300) @(negedge clk);
      bus0.key_valid = 1'b0; bus1.key_valid = 1'b0;
      check("sat m0 count", 64'(bus0.entry_count), 64'd255);
      check("sat m1 count", 64'(bus1.entry_count), 64'd255);
      repeat (5) @(negedge clk);
      check("sat m0 hold", 64'(bus0.entry_count), 64'd255);

      // 6. reset at counter 5 with digit_sel = 2, overriding key and clear
      wait_sel(1, "pre-rst sel1");
      wait_sel(2, "pre-rst sel2");
      repeat (4) @(negedge clk);
      check("pre-rst sel", 64'(bus0.digit_sel), 64'd2);
      rst = 1'b1;
      bus0.key_valid = 1'b1; bus0.clear = 1'b1;
      bus1.key_valid = 1'b1; bus1.clear = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus0.key_valid = 1'b0; bus0.clear = 1'b0;
      bus1.key_valid = 1'b0; bus1.clear = 1'b0;
      check("mid-rst seg", 64'(bus0.seg), 64'd0);
      check("mid-rst sel", 64'(bus0.digit_sel), 64'd0);
      check("mid-rst digits", 64'(bus0.digits), 64'd0);
      check("mid-rst valid", 64'(bus1.digit_valid), 64'd0);
      check("mid-rst count", 64'(bus1.entry_count), 64'd0);
      repeat (8) @(negedge clk);
      check("restart sel hold", 64'(bus0.digit_sel), 64'd0);
      @(negedge clk);
      check("restart sel step", 64'(bus0.digit_sel), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_ssd_scanner.md
# keypad_ssd_scanner

Parametrised keypad-entry display engine for the keypad/SSD Pmod path. It sits after `keypad_decoder` and the key-press `single_pulse_detector`. It captures accepted key codes into `NUM_DIGITS` digit registers, then time-multiplexes them onto one shared 7-segment bus with a registered digit select. It supersedes the fixed two-digit `chip_sel` toggling and adds two entry modes, a clear function, leading-digit blanking and an entry counter.

## Interface
Parameters:
- `clk_freq`, 125_000_000, input clock frequency in Hz.
- `refresh_hz`, 1000, digit-advance rate in Hz. `DIV = clk_freq/refresh_hz` must be ≥ 2.
- `NUM_DIGITS`, 2, number of digit slots, 1..8. `SEL_W = max(1, $clog2(NUM_DIGITS))`.
- `ENTRY_MODE`, 0. 0 = round-robin overwrite. 1 = shift-left entry.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1. One clock; reset is synchronous and active-high.
- `key_valid`, in, 1, single-cycle pulse, one per accepted key press.
- `key_code`, in, 4, hex code sampled when `key_valid` = 1.
- `clear`, in, 1, single-cycle pulse that erases all entries.
- `seg`, out, 7, active-high segments, `seg[6:0]` = {a,b,c,d,e,f,g}, registered.
- `digit_sel`, out, SEL_W, index of the digit currently driven on `seg`, registered. On the 2-digit Pmod, `chip_sel = digit_sel[0]`.
- `digits`, out, 4*NUM_DIGITS, flat digit registers, slot k at bits [4k+3:4k].
- `digit_valid`, out, NUM_DIGITS, per-slot "entered since clear" mask.
- `entry_count`, out, 8, keys accepted since clear or reset, saturating at 255.

## Operation
- Font is the same hex font as `disp_ctrl`. Examples: 0=1111110, 1=0110000, 2=1101101, 8=1111111, A=1110111, F=1000111.
- A slot with `digit_valid` = 0 displays blank, `seg` = 0000000.
- Entry, ENTRY_MODE 0:
  - `key_valid` writes `key_code` into slot `wr_ptr` and sets `digit_valid[wr_ptr]`.
  - `wr_ptr` increments and wraps from NUM_DIGITS-1 to 0.
- Entry, ENTRY_MODE 1:
  - `key_valid` shifts slot k into k+1 for all slots; slot NUM_DIGITS-1 is discarded.
  - `key_code` enters slot 0 and `digit_valid` shifts the same way, with 1 entering bit 0.
  - `wr_ptr` is unused and held at 0.
- `entry_count` increments on each accepted key and saturates at 255; it never wraps.
- `clear` zeroes all digits, `digit_valid`, `wr_ptr` and `entry_count`.
- `clear` and `key_valid` in the same cycle: `clear` wins and the key is dropped.
- Scan:
  - A refresh counter counts 0..DIV-1.
  - At terminal count DIV-1, the counter returns to 0 and the internal `scan_idx` advances, wrapping from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS = 1, `scan_idx` stays at 0.
- Output register: each cycle, `digit_sel` ← `scan_idx` and `seg` ← font(slot `scan_idx`), blanked if that slot is not valid.

## Timing
- Reset values:
  - `seg` = 0000000, `digit_sel` = 0.
  - `digits` = 0, `digit_valid` = 0, `entry_count` = 0.
  - `wr_ptr` = 0, `scan_idx` = 0, refresh counter = 0.
- Reset applied mid-scan or mid-entry takes effect on the next clock edge and overrides `key_valid` and `clear`.
- Key accepted at edge n:
  - `digits`, `digit_valid` and `entry_count` update at n+1.
  - `seg` shows the new value at n+2 if that slot is selected.
- `scan_idx` advances on the edge where the counter equals DIV-1; `digit_sel` and `seg` change together one cycle later.
- Each digit is therefore displayed for exactly DIV cycles, and `seg` never shows a value mismatched to `digit_sel`.
- `key_valid` held high for m cycles is treated as m keys. Pulse shaping is the upstream detector's job.

## Test plan
Bench parameters: `clk_freq`=8, `refresh_hz`=1 (DIV=8), NUM_DIGITS=4, both ENTRY_MODE values.
1. Reset → `seg`=0000000, `digit_sel`=0, `digits`=0, `digit_valid`=0000, `entry_count`=0; `digit_sel` steps 0,1,2,3,0 every 8 cycles with `seg` staying blank.
2. Mode 0, keys 1,2,3,4,5 → `digits`=0x4325 (slot0 overwritten by 5), `digit_valid`=1111, `entry_count`=5; when `digit_sel`=0, `seg`=1011011.
3. Mode 1, keys A,2 → slot0=2, slot1=A, `digit_valid`=0011; `digit_sel`=1 shows 1110111, `digit_sel`=2 shows 0000000.
4. `clear` and `key_valid` (code 8) in the same cycle after 3 entries → all digits 0, `digit_valid`=0000, `entry_count`=0, no 8 stored.
5. 300 key pulses → `entry_count`=255, holding.
6. Assert `rst` for one cycle during counter value 5 with `digit_sel`=2 → next cycle all registers at reset values and the counter restarts at 0.
